// File: rtl/serial_rim_pkg.sv
// serial_rim_pkg: shared FSM state encoding, default widths and command codes for serial_rim.
package serial_rim_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_CMD,
    ST_RX_ADDR,
    ST_RX_DATA,
    ST_REQ,
    ST_WAIT,
    ST_TX
  } state_t;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;
endpackage

// File: rtl/serial_rim_shift.sv
// serial_rim_shift: parameterised MSB-first shift register with parallel load.
// Ports: clk/rst (async active-high clear); load/d parallel load (wins over shift);
//   shift/din shift one place toward the MSB taking din at the LSB; q register contents.
module serial_rim_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         shift,
  input  logic         din,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {q[W-2:0], din};
  end
endmodule

// File: rtl/serial_rim.sv
// serial_rim: serial command front end that turns sdi frames into register-slave requests
//   and returns read data serially on sdo.
// Ports: clk, rst (async active-high); sdi serial command in, sdo serial response out (both idle high);
//   busy high outside IDLE; req/cmd/addr/data_to_ris request to the slave;
//   rdy/wr_done/rd_data slave response; frame_done end-of-transaction pulse; err sticky timeout flag.
// Build option: define SERIAL_RIM_TIMEOUT_EN to abandon WAIT after TIMEOUT cycles and raise err.
module serial_rim
  import serial_rim_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdi,
  output logic              sdo,
  output logic              busy,
  output logic              req,
  output logic              cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_to_ris,
  input  logic              rdy,
  input  logic              wr_done,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_done,
  output logic              err
);
`ifdef SERIAL_RIM_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif
  localparam int TX_W = DATA_W + 2;
  localparam logic [4:0] A_LAST  = 5'(ADDR_W - 1);
  localparam logic [4:0] D_LAST  = 5'(DATA_W - 1);
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);
  state_t r_state, w_next;
  logic [4:0] r_cnt;
  logic r_cmd, r_rdy_seen, r_frame_done, r_err;
  logic w_capture, w_wr_end, w_timeout, w_tx_last;
  logic [TX_W-1:0] w_tx_q;
  assign w_capture = r_state == ST_WAIT && r_cmd == CMD_RD && rdy && r_rdy_seen;
  assign w_wr_end  = r_state == ST_WAIT && r_cmd == CMD_WR && wr_done;
  assign w_timeout = TO_EN && r_state == ST_WAIT && !w_capture && !w_wr_end && r_cnt == TO_LAST;
  // TX register holds {start, data, sentinel}; the frame's last bit is on sdo once the
  // sentinel has reached the bit just below the MSB with only zeros behind it.
  assign w_tx_last = w_tx_q[TX_W-2:0] == {1'b1, {DATA_W{1'b0}}};
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = sdi ? ST_IDLE : ST_RX_CMD;
      ST_RX_CMD:  w_next = ST_RX_ADDR;
      ST_RX_ADDR: w_next = r_cnt != A_LAST ? ST_RX_ADDR : r_cmd == CMD_WR ? ST_RX_DATA : ST_REQ;
      ST_RX_DATA: w_next = r_cnt == D_LAST ? ST_REQ : ST_RX_DATA;
      ST_REQ:     w_next = ST_WAIT;
      ST_WAIT:    w_next = w_capture ? ST_TX : (w_wr_end || w_timeout) ? ST_IDLE : ST_WAIT;
      ST_TX:      w_next = w_tx_last ? ST_IDLE : ST_TX;
      default:    w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cmd        <= CMD_RD;
      r_rdy_seen   <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_next != r_state ? 5'd0 : r_cnt + 5'd1;
      r_cmd        <= r_state == ST_RX_CMD ? sdi : r_cmd;
      // Remembers that the previous WAIT cycle had rdy=1; any rdy=0 cycle drops it.
      r_rdy_seen   <= r_state == ST_WAIT && r_cmd == CMD_RD && rdy && !w_capture;
      r_frame_done <= w_wr_end || (r_state == ST_TX && w_tx_last);
      r_err        <= w_timeout ? 1'b1 : (r_state == ST_IDLE && !sdi) ? 1'b0 : r_err;
    end
  end
  serial_rim_shift #(.W(ADDR_W)) u_addr (
    .clk(clk), .rst(rst), .load(1'b0), .d({ADDR_W{1'b0}}),
    .shift(r_state == ST_RX_ADDR), .din(sdi), .q(addr)
  );
  serial_rim_shift #(.W(DATA_W)) u_data (
    .clk(clk), .rst(rst), .load(1'b0), .d({DATA_W{1'b0}}),
    .shift(r_state == ST_RX_DATA), .din(sdi), .q(data_to_ris)
  );
  serial_rim_shift #(.W(TX_W)) u_tx (
    .clk(clk), .rst(rst), .load(w_capture), .d({1'b0, rd_data, 1'b1}),
    .shift(r_state == ST_TX), .din(1'b0), .q(w_tx_q)
  );
  assign sdo        = r_state == ST_TX ? w_tx_q[TX_W-1] : 1'b1;
  assign busy       = r_state != ST_IDLE;
  assign req        = r_state == ST_REQ;
  assign cmd        = r_cmd;
  assign frame_done = r_frame_done;
  assign err        = TO_EN && r_err;
endmodule

// File: tb/tb_serial_rim.sv
// tb_serial_rim: randomized scoreboard bench for serial_rim with a behavioural register-slave model.
module tb_serial_rim;
  logic clk = 1'b0;
  logic rst, sdi, sdo, busy, req, cmd, rdy, wr_done, frame_done, err;
  logic [7:0] addr;
  logic [15:0] data_to_ris, rd_data;
  serial_rim dut (
    .clk(clk), .rst(rst), .sdi(sdi), .sdo(sdo), .busy(busy), .req(req), .cmd(cmd),
    .addr(addr), .data_to_ris(data_to_ris), .rdy(rdy), .wr_done(wr_done),
    .rd_data(rd_data), .frame_done(frame_done), .err(err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { logic c; logic [7:0] a; logic [15:0] d; } req_t;
  typedef struct { logic [15:0] d; int lat; logic [7:0] a; } rd_t;
  req_t req_q[$];
  rd_t rd_q[$];
  int fd_q[$];
  bit rdy_pat[$];
  logic [15:0] rd_vals[$];
  int wr_lat = 1;
  bit slave_mute = 0;
  bit chk_err_clr = 0;
  int n_cmp = 0, n_err = 0, n_req = 0, req_cyc = 0;
  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction
  // register-slave model: answers each req according to the current stimulus settings
  initial begin
    rdy = 0; wr_done = 0; rd_data = 0;
    forever begin
      @(negedge clk);
      if (req === 1'b1 && !slave_mute) begin
        if (cmd) begin
          repeat (wr_lat) @(negedge clk);
          wr_done = 1;
          fd_q.push_back(cyc + 1);
          @(negedge clk) wr_done = 0;
        end else begin
          foreach (rdy_pat[i]) begin
            @(negedge clk);
            rdy = rdy_pat[i];
            rd_data = rd_vals[i];
          end
          @(negedge clk);
          rdy = 0;
          rd_data = 16'($urandom);
        end
      end
    end
  end
  // request monitor
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (req === 1'b1) begin
        n_req++;
        req_cyc = cyc;
        check("req_pending", req_q.size() > 0, 1);
        if (req_q.size() > 0) begin
          e = req_q.pop_front();
          check("req_cmd", cmd, e.c);
          check("req_addr", addr, e.a);
          if (e.c) check("req_data", data_to_ris, e.d);
        end
      end
    end
  end
  // serial response monitor
  initial begin
    rd_t e;
    logic [15:0] got;
    bit have;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && sdo === 1'b0) begin
        have = rd_q.size() > 0;
        check("rd_pending", have, 1);
        if (have) begin
          e = rd_q.pop_front();
          check("rd_latency", cyc - req_cyc, e.lat);
          check("addr_hold", addr, e.a);
        end
        for (int i = 15; i >= 0; i--) begin
          @(negedge clk);
          got[i] = sdo;
        end
        if (have) check("tx_data", got, e.d);
        fd_q.push_back(cyc + 1);
        @(negedge clk);
        check("sdo_idle", sdo, 1);
        check("busy_after_tx", busy, 0);
      end
    end
  end
  // frame_done monitor
  initial begin
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        check("fd_pending", fd_q.size() > 0, 1);
        if (fd_q.size() > 0) check("fd_cycle", cyc, fd_q.pop_front());
      end
    end
  end
  task automatic send_frame(input logic c, input logic [7:0] a, input logic [15:0] d);
    req_q.push_back(req_t'{c, a, d});
    @(negedge clk) sdi = 0;
    @(negedge clk) sdi = c;
    if (chk_err_clr) check("err_cleared", err, 0);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) sdi = a[i];
    end
    if (c) begin
      for (int i = 15; i >= 0; i--) begin
        @(negedge clk) sdi = d[i];
      end
    end
    @(negedge clk) sdi = 1;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("idle_in_time", busy, 0);
    check("err_low", err, 0);
  endtask
  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input int lat);
    wr_lat = lat;
    send_frame(1, a, d);
    wait_idle();
    repeat (2) @(negedge clk);
  endtask
  // expected capture is the first rdy=1 cycle preceded by another rdy=1 cycle
  task automatic do_read(input logic [7:0] a, input bit noise);
    int j = -1;
    for (int i = 1; i < rdy_pat.size(); i++)
      if (j < 0 && rdy_pat[i] && rdy_pat[i-1]) j = i;
    rd_q.push_back(rd_t'{rd_vals[j], j + 2, a});
    send_frame(0, a, 16'($urandom));
    if (noise) begin
      int k = 0;
      while (sdo && k < 50) begin
        @(negedge clk);
        k++;
      end
      repeat (3) @(negedge clk);
      sdi = 0;
      @(negedge clk) sdi = 1;
    end
    wait_idle();
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int n0, k;
    rst = 1;
    sdi = 1;
    repeat (3) @(negedge clk);
    check("rst_sdo", sdo, 1);
    check("rst_busy", busy, 0);
    check("rst_req", req, 0);
    check("rst_cmd", cmd, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data_to_ris, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    do_write(8'h3C, 16'hA5F0, 2);
    rdy_pat = '{0, 1, 1};
    rd_vals = '{16'h1111, 16'h2222, 16'hBEEF};
    do_read(8'h12, 1);
    rdy_pat = '{1, 0, 1, 1};
    rd_vals = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h5A3C};
    do_read(8'h81, 0);
    // reset during the 5th address bit abandons the frame
    n0 = n_req;
    @(negedge clk) sdi = 0;
    @(negedge clk) sdi = 1;
    repeat (4) @(negedge clk) sdi = 1'($urandom_range(0, 1));
    @(negedge clk) sdi = 1;
    #2 rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_addr", addr, 0);
    check("abort_sdo", sdo, 1);
    @(negedge clk);
    @(negedge clk) rst = 0;
    repeat (2) @(negedge clk);
    check("abort_no_req", n_req, n0);
    do_write(8'hC3, 16'h0F5A, 1);
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write(8'($urandom), 16'($urandom), $urandom_range(1, 6));
      end else begin
        rdy_pat.delete();
        rd_vals.delete();
        for (int i = 0; i < $urandom_range(0, 5); i++) rdy_pat.push_back($urandom_range(0, 1) == 1);
        rdy_pat.push_back(1);
        rdy_pat.push_back(1);
        foreach (rdy_pat[i]) rd_vals.push_back(16'($urandom));
        do_read(8'($urandom), $urandom_range(0, 1) == 1);
      end
    end
`ifdef SERIAL_RIM_TIMEOUT_EN
    slave_mute = 1;
    send_frame(0, 8'h55, 16'h0000);
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", cyc - req_cyc, 16);
    check("timeout_idle", busy, 0);
    check("err_set", err, 1);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    slave_mute = 0;
    chk_err_clr = 1;
    wr_lat = 1;
    send_frame(1, 8'hA0, 16'h1234);
    chk_err_clr = 0;
    wait_idle();
    repeat (2) @(negedge clk);
`else
    do_write(8'h7E, 16'hFFFF, 40);
`endif
    check("req_q_empty", req_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("fd_q_empty", fd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
